// File: rtl/ac97_pkg.sv
// Shared frame geometry, FSM state type and slot boundary helper for the
// AC-link serial-out framer.
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int TAG_BITS   = 16;
    localparam int SLOT_W     = 20;
    localparam int NUM_SLOTS  = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit position of the last bit before slot s (1..12) starts.
    function automatic logic [7:0] slot_last_bit(input int s);
        return 8'(TAG_BITS - 1 + SLOT_W * (s - 1));
    endfunction

endpackage

// File: rtl/ac97_frame_counter.sv
// Frame bit counter with registered sync and slot-boundary decode.
// All decode outputs derive from flops only.
module ac97_frame_counter
    import ac97_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 start,
    output logic [7:0]           bit_cnt,
    output logic                 sync_pad_o,
    output logic [NUM_SLOTS-1:0] slot_hit,
    output logic [3:0]           slot_idx,
    output logic                 frame_end
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            sync_pad_o <= 1'b0;
        end else if (start) begin
            bit_cnt    <= '0;
            sync_pad_o <= 1'b1;
        end else if (run) begin
            // Bit 255 wraps to 0 here when the frame stops; the top drops run.
            bit_cnt    <= bit_cnt + 8'd1;
            sync_pad_o <= (bit_cnt < 8'(TAG_BITS - 1));
        end else begin
            bit_cnt    <= '0;
            sync_pad_o <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_hit
            assign slot_hit[gi] = run && (bit_cnt == slot_last_bit(gi + 1));
        end
    endgenerate

    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_hit[i]) begin
                slot_idx = slot_idx | 4'(i + 1);
            end
        end
    end

    assign frame_end = run && (bit_cnt == 8'(FRAME_BITS - 1));

endmodule

// File: rtl/ac97_sdata_out_framer.sv
// AC97 serial-out framer: builds 16-bit tag + twelve 20-bit slots per frame
// and shifts them MSB-first onto sdata_pad_o with a registered sync.
module ac97_sdata_out_framer
    import ac97_pkg::*;
#(
    parameter logic [1:0] CODEC_ID = 2'b00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 frame_valid,
    input  logic [NUM_SLOTS-1:0] slot_valid,
    input  logic [SLOT_W-1:0]    slot_data,
    output logic                 slot_ld,
    output logic [3:0]           slot_idx,
    output logic                 sdata_pad_o,
    output logic                 sync_pad_o,
    output logic                 frame_done,
    output logic                 busy
);

    state_t                 state_reg;
    logic [SLOT_W-1:0]      shift_reg;
    logic [NUM_SLOTS-1:0]   mask_reg;
    logic [TAG_BITS-1:0]    tag;
    logic [NUM_SLOTS-1:0]   slot_hit;
    logic [7:0]             bit_cnt;
    logic                   run;
    logic                   start;
    logic                   frame_end;

    // Slot 1 valid lands at tag bit 14, slot 12 at tag bit 3.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_tag
            assign tag[14 - gi] = slot_valid[gi];
        end
    endgenerate
    assign tag[15]  = frame_valid;
    assign tag[2]   = 1'b0;
    assign tag[1:0] = CODEC_ID;

    assign run   = (state_reg == RUN);
    // en only matters in IDLE and on the last bit of a frame.
    assign start = en && (!run || frame_end);

    ac97_frame_counter u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .start      (start),
        .bit_cnt    (bit_cnt),
        .sync_pad_o (sync_pad_o),
        .slot_hit   (slot_hit),
        .slot_idx   (slot_idx),
        .frame_end  (frame_end)
    );

    assign slot_ld = |(slot_hit & mask_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            mask_reg  <= '0;
        end else if (start) begin
            state_reg <= RUN;
            shift_reg <= {tag, 4'b0000};
            mask_reg  <= slot_valid;
        end else if (frame_end) begin
            state_reg <= IDLE;
            shift_reg <= '0;
        end else if (run) begin
            if (|slot_hit) begin
                shift_reg <= slot_ld ? slot_data : '0;
            end else begin
                shift_reg <= {shift_reg[SLOT_W-2:0], 1'b0};
            end
        end
    end

    assign sdata_pad_o = shift_reg[SLOT_W-1];
    assign frame_done  = frame_end;
    assign busy        = run;

endmodule

// File: tb/tb_ac97_sdata_out_framer.sv
// Self-checking bench: frame-image model compared every cycle, plus directed
// literal checks on tag, slot payloads, fetch strobes, stop and reset.
module tb_ac97_sdata_out_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        frame_valid = 1'b0;
    logic [11:0] slot_valid = '0;
    logic [19:0] slot_data = '0;
    logic        slot_ld;
    logic [3:0]  slot_idx;
    logic        sdata_pad_o;
    logic        sync_pad_o;
    logic        frame_done;
    logic        busy;

    ac97_sdata_out_framer #(.CODEC_ID(2'b00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .frame_valid (frame_valid),
        .slot_valid  (slot_valid),
        .slot_data   (slot_data),
        .slot_ld     (slot_ld),
        .slot_idx    (slot_idx),
        .sdata_pad_o (sdata_pad_o),
        .sync_pad_o  (sync_pad_o),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: the whole 256-bit frame image plus the position on the pad.
    bit        m_run = 1'b0;
    int        m_pos = 0;
    bit        m_frame[256];
    bit [11:0] m_mask = '0;
    logic [1:0] codec_id_v = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fetch_slot(input int pos);
        if (pos >= 15 && pos <= 235 && ((pos - 15) % 20) == 0) return (pos - 15) / 20 + 1;
        return 0;
    endfunction

    task automatic m_start();
        m_run = 1'b1;
        m_pos = 0;
        for (int b = 0; b < 256; b++) m_frame[b] = 1'b0;
        m_frame[0] = frame_valid;
        for (int i = 0; i < 12; i++) m_frame[1 + i] = slot_valid[i];
        m_frame[13] = 1'b0;
        m_frame[14] = codec_id_v[1];
        m_frame[15] = codec_id_v[0];
        m_mask = slot_valid;
    endtask

    task automatic m_step();
        int s;
        if (!m_run) begin
            if (en) m_start();
        end else begin
            s = fetch_slot(m_pos);
            if (s != 0) begin
                for (int k = 0; k < 20; k++)
                    m_frame[16 + 20 * (s - 1) + k] = m_mask[s - 1] ? slot_data[19 - k] : 1'b0;
            end
            if (m_pos == 255) begin
                if (en) m_start();
                else m_run = 1'b0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic compare_all();
        int s;
        s = m_run ? fetch_slot(m_pos) : 0;
        chk("busy", busy, m_run);
        chk("sdata", sdata_pad_o, m_run && m_frame[m_pos]);
        chk("sync", sync_pad_o, m_run && (m_pos < 16));
        chk("frame_done", frame_done, m_run && (m_pos == 255));
        chk("slot_idx", slot_idx, s);
        chk("slot_ld", slot_ld, (s != 0) && m_mask[s - 1]);
    endtask

    task automatic run_frame(input int chg_at, input logic chg_en, input logic [11:0] chg_sv,
                             input logic [19:0] chg_data, input int dz_at,
                             output logic [255:0] cap, output logic [255:0] ld_map,
                             output int fd_pos, output int sync_cnt);
        cap = '0;
        ld_map = '0;
        fd_pos = -1;
        sync_cnt = 0;
        for (int c = 0; c < 256; c++) begin
            @(posedge clk);
            #1;
            cap[c] = sdata_pad_o;
            ld_map[c] = slot_ld;
            if (frame_done && fd_pos < 0) fd_pos = c;
            if (sync_pad_o) sync_cnt++;
            @(negedge clk);
            if (c == chg_at) begin
                en = chg_en;
                slot_valid = chg_sv;
                slot_data = chg_data;
            end
            if (c == dz_at) slot_data = '0;
        end
    endtask

    function automatic logic [15:0] tag_of(input logic [255:0] cap);
        logic [15:0] t;
        t = '0;
        for (int b = 0; b < 16; b++) t = {t[14:0], cap[b]};
        return t;
    endfunction

    logic [255:0] cap, ld_map, exp_ld;
    logic [19:0]  slot1;
    int           fd_pos, sync_cnt, waited, cnt;

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        frame_valid = 1'b1;
        slot_valid = 12'hFFF;
        slot_data = 20'hA5A5A;

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) m_run = 1'b0;
                else m_step();
            end
            forever begin
                @(posedge clk);
                #1;
                compare_all();
            end
        join_none

        // Reset held with en=1: nothing may come out.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", {sdata_pad_o, sync_pad_o, busy, slot_ld, frame_done, slot_idx}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: full valid mask, slot 1 = A5A5A; mask change at bit 50.
        run_frame(50, 1'b1, 12'h003, 20'hFFFFF, 16, cap, ld_map, fd_pos, sync_cnt);
        chk("f1_tag", tag_of(cap), 32'hFFF8);
        for (int k = 0; k < 20; k++) slot1[19 - k] = cap[16 + k];
        chk("f1_slot1", slot1, 32'hA5A5A);
        exp_ld = '0;
        for (int k = 0; k < 12; k++) exp_ld[15 + 20 * k] = 1'b1;
        chk("f1_ld_map_diff", $countones(ld_map ^ exp_ld), 0);
        chk("f1_done_pos", fd_pos, 255);
        chk("f1_sync_cycles", sync_cnt, 16);
        $display("frame1 tag=%04h slot1=%05h ld=%0d done_at=%0d", tag_of(cap), slot1,
                 $countones(ld_map), fd_pos);

        // Frame 2: back-to-back, new mask 003; en dropped at bit 100.
        run_frame(100, 1'b0, 12'h003, 20'hFFFFF, -1, cap, ld_map, fd_pos, sync_cnt);
        chk("f2_tag", tag_of(cap), 32'hE000);
        exp_ld = '0;
        exp_ld[15] = 1'b1;
        exp_ld[35] = 1'b1;
        chk("f2_ld_map_diff", $countones(ld_map ^ exp_ld), 0);
        chk("f2_slots12_ones", $countones(cap[55:16]), 40);
        chk("f2_tail_ones", $countones(cap[255:56]), 0);
        chk("f2_done_pos", fd_pos, 255);
        chk("f2_sync_cycles", sync_cnt, 16);
        $display("frame2 tag=%04h ld=%0d done_at=%0d", tag_of(cap), $countones(ld_map), fd_pos);

        @(posedge clk);
        #1;
        chk("stop_idle", {busy, sync_pad_o, sdata_pad_o}, 0);
        $display("stop busy=%0b sync=%0b sdata=%0b", busy, sync_pad_o, sdata_pad_o);

        // Randomised traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 7) != 0);
            frame_valid = 1'($urandom);
            slot_valid = 12'($urandom);
            slot_data = 20'($urandom);
        end
        $display("random phase done cycles=3000");

        // Reset pulse in the middle of a frame.
        @(negedge clk);
        en = 1'b1;
        waited = 0;
        while (!(m_run && m_pos == 130) && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("reach_bit130", waited < 2000, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {sdata_pad_o, sync_pad_o, busy, slot_ld, frame_done, slot_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("sync_rise_after_reset", sync_pad_o, 1);
        cnt = 0;
        while (sync_pad_o && cnt < 300) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        chk("sync_cycles_after_reset", cnt, 16);
        $display("reset mid-frame: sync high for %0d cycles", cnt);

        repeat (20) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
